reg_file_scoreboard: RTL
========================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 The module SHALL use one clock and an asynchronous active-low reset:
  clk  in  1  rising-edge clock for all state.
  rst_n  in  1  asynchronous reset, active low.
REQ-002 The module SHALL have the following write-side ports:
  we  in  1  writeback enable.
  waddr  in  5  writeback register index.
  wdata  in  32  writeback data.
REQ-003 The module SHALL have the following read-side ports:
  raddr1  in  5  read port 1 index.
  raddr2  in  5  read port 2 index.
  rdata1  out  32  read port 1 data.
  rdata2  out  32  read port 2 data.
  byp1  out  1  rdata1 taken from wdata (same-cycle bypass).
  byp2  out  1  rdata2 taken from wdata (same-cycle bypass).
REQ-004 The module SHALL have the following scoreboard ports:
  issue_valid  in  1  an instruction with a register destination issues this cycle.
  issue_dest  in  5  destination index of the issuing instruction.
  flush  in  1  discard all pending writes.
  busy1  out  1  raddr1 awaits an unwritten result.
  busy2  out  1  raddr2 awaits an unwritten result.
  stall  out  1  busy1 OR busy2.

Function
REQ-005 Storage SHALL be 32 x 32-bit registers; register 0 SHALL read 0 and ignore writes.
REQ-006 A write SHALL commit at a rising clk edge when we=1 and waddr!=0.
REQ-007 Reads SHALL be combinational (0-cycle latency).
REQ-008 Port n bypass: when we=1, waddr==raddrn and waddr!=0, rdatan SHALL equal wdata and bypn SHALL be 1. Otherwise rdatan SHALL equal stored data and bypn SHALL be 0.
REQ-009 raddrn==0 SHALL give rdatan=0 and bypn=0 regardless of we or waddr.
REQ-010 The scoreboard SHALL be a 32-bit pending vector; bit 0 SHALL be constant 0.
REQ-011 At a rising edge, pending[issue_dest] SHALL set when issue_valid=1 and issue_dest!=0.
REQ-012 At a rising edge, pending[waddr] SHALL clear when we=1.
REQ-013 If a set and a clear target the same index in one cycle, set SHALL win.
REQ-014 flush=1 SHALL clear every pending bit at the edge. An issue in the same cycle SHALL still set its bit (flush precedes issue).
REQ-015 busyn SHALL equal pending[raddrn] AND NOT (we AND waddr==raddrn); a same-cycle writeback satisfies the read.
REQ-016 stall SHALL be combinational; stall has no effect on internal state.
REQ-017 A write to a non-pending register SHALL be legal and SHALL update storage normally.
REQ-018 Outputs SHALL be glitch-tolerant combinational decodes only; the module has no internal FSM beyond the storage and pending registers.

Reset
REQ-019 rst_n=0 SHALL immediately clear all 32 registers and all pending bits, independent of clk.
REQ-020 During reset: rdata1=rdata2=0, busy1=busy2=stall=0, and byp1/byp2 SHALL follow REQ-008 from live inputs.
REQ-021 An edge coinciding with rst_n=0 SHALL not commit writes or issues.

Structure
REQ-022 The shared package SHALL hold REG_COUNT=32, REG_AW=5, DATA_W=32 and the constant ZERO_REG=0.
REQ-023 One sub-module, reg_read_port, SHALL implement bypass, zero-forcing and busy decode, instantiated twice.

Verification
REQ-024 Reset, write r5=0xDEADBEEF, next cycle raddr1=5 -> rdata1=0xDEADBEEF, byp1=0.
REQ-025 we=1, waddr=7, wdata=0x12345678, raddr1=raddr2=7 in the same cycle -> rdata1=rdata2=0x12345678, byp1=byp2=1.
REQ-026 Write r0=0xFFFFFFFF, raddr1=0 in the same cycle and the next -> rdata1=0, byp1=0 both cycles.
REQ-027 issue_dest=9, then raddr2=9 with we=0 -> busy2=1, stall=1. The next cycle we=1, waddr=9 -> busy2=0 combinationally, and pending is clear afterwards.
REQ-028 issue_dest=4 and we/waddr=4 in the same cycle -> pending[4]=1 after the edge (set wins). Then flush=1 -> busy on raddr1=4 drops to 0.
REQ-029 Assert rst_n=0 asynchronously mid-cycle with r3 and pending[3] set -> rdata(r3)=0 and busy=0 before the next clk edge.

Source files
------------

// File: rtl/reg_file_scoreboard_pkg.sv
// Shared sizing constants for the register file / scoreboard slice.
package reg_file_scoreboard_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;
    localparam int DATA_W    = 32;

    // Architectural zero register: always reads 0, never pending.
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_file_scoreboard_reg_read_port.sv
// One read port: same-cycle writeback bypass, zero-register forcing and busy decode.
module reg_read_port
    import reg_file_scoreboard_pkg::*;
(
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] stored,
    input  logic              pending,
    output logic [DATA_W-1:0] rdata,
    output logic              byp,
    output logic              busy
);

    logic wb_hit;

    // A writeback to the same non-zero index satisfies this read in the same cycle.
    always_comb begin
        wb_hit = we && (waddr == raddr) && (raddr != ZERO_REG);
        byp    = wb_hit;
        busy   = pending && !(we && (waddr == raddr));
        // Data is forced to zero while in reset even if the bypass flag is raised
        // from live inputs; storage is already cleared, so only the bypass path needs it.
        if (!rst_n || raddr == ZERO_REG) begin
            rdata = '0;
        end else if (wb_hit) begin
            rdata = wdata;
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// 32x32 register file with two combinational read ports and a pending-write scoreboard.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              byp1,
    output logic              byp2,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic              flush,
    output logic              busy1,
    output logic              busy2,
    output logic              stall
);

    logic [DATA_W-1:0]    regs [REG_COUNT];
    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_next;

    // Storage: writes to r0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != ZERO_REG) begin
            regs[waddr] <= wdata;
        end
    end

    // Scoreboard update: flush and writeback clear first, then issue sets (set wins).
    always_comb begin
        pending_next = pending;
        if (flush) begin
            pending_next = '0;
        end
        if (we) begin
            pending_next[waddr] = 1'b0;
        end
        if (issue_valid && issue_dest != ZERO_REG) begin
            pending_next[issue_dest] = 1'b1;
        end
        pending_next[ZERO_REG] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    reg_read_port u_port1 (
        .rst_n   (rst_n),
        .raddr   (raddr1),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .stored  (regs[raddr1]),
        .pending (pending[raddr1]),
        .rdata   (rdata1),
        .byp     (byp1),
        .busy    (busy1)
    );

    reg_read_port u_port2 (
        .rst_n   (rst_n),
        .raddr   (raddr2),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .stored  (regs[raddr2]),
        .pending (pending[raddr2]),
        .rdata   (rdata2),
        .byp     (byp2),
        .busy    (busy2)
    );

    // Stall is a pure decode of the two busy flags.
    always_comb begin
        stall = busy1 | busy2;
    end

endmodule
